// File: rtl/fib_pair_serializer.sv
// Pair-in, single-out FIFO serializer for a double-rate Fibonacci source.
// Optional output-stream recurrence checker enabled by defining FIB_CHECK_EN.
module fib_pair_serializer #(
    parameter int W     = 16,
    parameter int DEPTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic [W-1:0]            in_num,
    input  logic [W-1:0]            in_num2,
    output logic                    in_ready,
    output logic                    out_valid,
    output logic [W-1:0]            out_num,
    input  logic                    out_ready,
    output logic [$clog2(DEPTH):0]  level,
    output logic                    drop
`ifdef FIB_CHECK_EN
    ,
    output logic                    err
`endif
);

    localparam int AW = $clog2(DEPTH);
    // Highest occupancy that still leaves room for a whole pair.
    localparam logic [AW:0] PUSH_MAX = (AW+1)'(DEPTH - 2);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          pop;
    logic [AW:0]   level_next;

    // Valid/ready: a transfer happens on an edge where both valid and ready are high.
    // in_ready depends only on the registered level, never on in_valid.
    assign in_ready  = (level <= PUSH_MAX);
    assign out_valid = (level != '0);
    assign out_num   = mem[rd_ptr];
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        level_next = level;
        if (push && pop) begin
            level_next = level + (AW+1)'(1);
        end else if (push) begin
            level_next = level + (AW+1)'(2);
        end else if (pop) begin
            level_next = level - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            drop   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(2);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            level <= level_next;
            if (in_valid && !in_ready) begin
                drop <= 1'b1;
            end
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr]          <= in_num;
            mem[wr_ptr + AW'(1)] <= in_num2;
        end
    end

`ifdef FIB_CHECK_EN
    logic [W-1:0] prev1;
    logic [W-1:0] prev0;
    logic [1:0]   pop_cnt;
    logic [W-1:0] fib_sum;

    // Truncated sum: wrap-around of large terms is still a valid recurrence.
    assign fib_sum = prev1 + prev0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev1   <= '0;
            prev0   <= '0;
            pop_cnt <= 2'd0;
            err     <= 1'b0;
        end else if (pop) begin
            if (pop_cnt == 2'd2 && out_num != fib_sum) begin
                err <= 1'b1;
            end
            prev1 <= prev0;
            prev0 <= out_num;
            if (pop_cnt != 2'd2) begin
                pop_cnt <= pop_cnt + 2'd1;
            end
        end
    end
`endif

endmodule

// File: doc/fib_pair_serializer.md
Name: fib_pair_serializer

Overview:
- Downstream stage of the double-rate Fibonacci generator, which has two 16-bit outputs.
- Accepts a pair of consecutive Fibonacci numbers per cycle and buffers them in a small FIFO.
- Emits one number per cycle on a valid/ready stream, in sequence order.
- The generator cannot stall, so refused pairs are counted as drops. An optional checker verifies the recurrence on the output stream.

Parameters:
W, 16, data width of each number.
DEPTH, 8, FIFO entries; power of 2, >= 4.

Ports:
clk  in  1  clock; all logic on posedge.
rst  in  1  asynchronous, active-low reset (0 = reset).
in_valid  in  1  pair present on in_num/in_num2.
in_num  in  W  first (older) number of pair.
in_num2  in  W  second (newer) number of pair.
in_ready  out  1  pair can be accepted this cycle.
out_valid  out  1  out_num holds a valid number.
out_num  out  W  head of FIFO (show-ahead).
out_ready  in  1  consumer takes out_num this cycle.
level  out  $clog2(DEPTH)+1  current FIFO occupancy.
drop  out  1  sticky: a pair was refused.
err  out  1  sticky recurrence error; present only with FIB_CHECK_EN.

Behaviour:
- Reset (rst=0, asynchronous):
  - rd/wr pointers, level, drop and err clear immediately.
  - out_valid=0, in_ready=1 while reset is held.
  - FIFO storage is not cleared.
  - Reset mid-stream discards all buffered data; there is no partial flush.
- in_ready = (DEPTH - level) >= 2. It is combinational from registered level only, never from in_valid.
- Push (in_valid && in_ready):
  - in_num is written at wr_ptr and in_num2 at wr_ptr+1; wr_ptr += 2.
  - Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Level uses the extra bit to tell full from empty.
- out_valid = (level != 0). out_num = mem[rd_ptr], combinational read of the registered pointer.
- Pop (out_valid && out_ready): rd_ptr += 1 (wrapping).
- Level update per cycle: level_next = level + 2*push - pop.
  - Push and pop in the same cycle: +1.
  - Pop on empty is ignored; out_ready while !out_valid has no effect.
  - Push when level = DEPTH-2 is allowed and fills the FIFO. At level DEPTH-1 or DEPTH the push is refused.
  - A pop in the same cycle does not enable a push; in_ready does not look ahead.
- Drop: in_valid && !in_ready sets drop=1 on that edge. The pair is discarded and FIFO contents are unchanged. drop stays set until reset.
- Latency: a pair pushed at edge N gives out_valid=1 after edge N when the FIFO was empty. in_num appears first; in_num2 follows on the next pop.
- Throughput: the sustained output rate is 1 number/cycle. With a free-running 2/cycle producer, drops are expected once the FIFO fills.

Optional Feature:
- Macro: FIB_CHECK_EN.
- Defined:
  - Adds registers prev1, prev0 (last two popped values) and a 2-bit saturating pop counter.
  - On every pop where the counter is already 2: if out_num != (prev1 + prev0) mod 2^W, err is set (sticky until reset). The W-bit sum is truncated, so wrap-around of large Fibonacci terms is not an error.
  - Each pop shifts prev0 into prev1 and out_num into prev0.
  - Reset clears prev regs, counter and err.
  - A drop breaks the sequence; err then rising is the required behaviour.
- Undefined: the err port and all checker logic are absent. Other behaviour is identical.

Test Plan:
- Reset, then push pair (0,1) with out_ready=0 -> level=2, out_valid=1, out_num=0. Pop -> out_num=1, level=1.
- Push 3 pairs back-to-back with out_ready=0, DEPTH=8 -> in_ready=1 until level=6; 4th pair accepted -> level=8, in_ready=0. 5th in_valid -> drop=1, level stays 8.
- Stream from a fibonacci_2-style source seeded (0,1), out_ready=1 for 40 cycles, source gated by in_ready -> outputs 0,1,1,2,3,5,...,46368, then 75025 mod 65536 = 9489. err=0, drop=0.
- Same stream with one pair corrupted (8 replaced by 9) -> err=1 on the pop after 9, stays 1. Also check err is absent with the macro off.
- Push and pop in the same cycle at level=3 -> level=4; pointers wrap correctly across index DEPTH-1 -> 0 with order preserved.
- Assert rst=0 mid-stream at level=5 with drop=1 -> asynchronously level=0, out_valid=0, drop=0, in_ready=1. The first push after release outputs in order.
